axi_lite_initiator: RTL and testbench
=====================================

Name: axi_lite_initiator

Overview:
- Initiator end of the team's 4-bit-address / 8-bit-data AXI-lite-style register interface; drives the memory-backed responder block.
- Accepts one command at a time (read or write) from a local command port.
- Runs the AR/R or AW/W/B handshakes and returns read data or write status on a one-cycle response strobe.
- Includes a per-transaction watchdog so a stalled responder cannot hang the initiator.

Parameters:
ADDR_W, 4, address width
DATA_W, 8, data width
TIMEOUT, 255, max cycles in any wait state before abort; 0 disables watchdog

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_W  read data, held until next completion
rsp_err  out  2  00 OKAY, 01 responder error, 10 timeout
m_arvalid  out  1  read address valid
m_araddr  out  ADDR_W  read address
s_arready  in  1  read address ready
s_rvalid  in  1  read data valid
s_rdata  in  DATA_W  read data
s_rresp  in  2  read response
m_rready  out  1  read data ready
m_awvalid  out  1  write address valid
m_awaddr  out  ADDR_W  write address
s_awready  in  1  write address ready
m_wvalid  out  1  write data valid
m_wdata  out  DATA_W  write data
s_wready  in  1  write data ready
s_bvalid  in  1  write response valid
s_bresp  in  2  write response
m_bready  out  1  write response ready

Behaviour:
- Reset (async assert, sync release): state IDLE; all valid/ready outputs 0 except cmd_ready=1; addr/data outputs 0; rsp_rdata=0, rsp_err=00, watchdog=0.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
- IDLE: on accept, latch addr/wdata; cmd_ready drops next cycle. A read goes to RD_ADDR with m_arvalid=1. A write goes to WR_ADDR_DATA with m_awvalid=1 and m_wvalid=1 on the same edge.
- Valid stability: once asserted, m_*valid and its addr/data stay constant until the matching ready is sampled high. Never drop valid early except on timeout abort.
- RD_ADDR: on arvalid && arready, m_arvalid=0, m_rready=1, go to RD_DATA.
- RD_DATA: on rvalid && rready, capture s_rdata into rsp_rdata, m_rready=0, and set rsp_err to 00 if s_rresp==00, otherwise 01. Go to DONE.
- WR_ADDR_DATA: AW and W handshakes complete independently, in either order or in the same cycle. Each valid drops the cycle after its own handshake. When both are done, m_bready=1 and go to WR_RESP.
- WR_RESP: on bvalid && bready, m_bready=0, rsp_err=00 if s_bresp==00 else 01, go to DONE. rsp_rdata is unchanged on writes.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. cmd_ready=1 again that next cycle.
- Minimum latency with a zero-wait responder: accept at cycle 0 → rsp_valid at cycle 3 for reads (AR handshake at cycle 1, R at 2). Writes with AW and W in the same cycle match this.
- Watchdog: resets to 0 on entering each wait state and on every completed handshake; increments while waiting.
  - When it reaches TIMEOUT, all m_* valid/ready drop to 0, rsp_err=10, and the state goes to DONE.
  - A late responder beat after an abort is ignored, because all m_* valid/ready are 0.
- Reset mid-transaction: all valid/ready outputs drop immediately and asynchronously. No response is generated.
- A cmd_valid asserted while not in IDLE is ignored; cmd_ready is 0 there.

Test Plan:
- Read, zero-wait responder returning 8'h5A at addr 3 → m_araddr=3, rsp_valid at cycle 3 after accept, rsp_rdata=8'h5A, rsp_err=00.
- Write addr 7 data 8'hC3; responder raises awready 2 cycles before wready; bresp=00 → m_awvalid low first, m_wvalid held until wready, m_bready only after both, rsp_err=00, rsp_rdata unchanged.
- Write with bresp=2'b11 → rsp_err=01. Read with rresp=2'b10 → rsp_err=01, rsp_rdata captured.
- TIMEOUT=4, responder never asserts arready → m_arvalid drops, rsp_valid with rsp_err=10 on the cycle after the watchdog hits 4; a later s_rvalid is ignored.
- reset_n pulsed low while in WR_RESP → m_bready=0 asynchronously, no rsp_valid, cmd_ready=1 after release. Back-to-back commands held on cmd_valid → second accepted the cycle after the first's rsp_valid.

Source files
------------

// File: rtl/axi_lite_initiator.sv
// axi_lite_initiator: single-outstanding AXI-lite initiator with a per-wait watchdog
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           local command handshake; cmd_write/cmd_addr/cmd_wdata describe it
//   rsp_valid/rsp_rdata/rsp_err   one-cycle completion strobe, read data, status (00 ok, 01 slave err, 10 timeout)
//   m_ar*/s_ar*, s_r*/m_rready    read address and read data channels
//   m_aw*/s_awready, m_w*/s_wready, s_b*/m_bready   write address, write data and write response channels
module axi_lite_initiator #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              m_rready,
  output logic              m_awvalid,
  output logic [ADDR_W-1:0] m_awaddr,
  input  logic              s_awready,
  output logic              m_wvalid,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  output logic              m_bready
);
  localparam int WD_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [WD_W-1:0] wd;
  logic aw_done, w_done;
  logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, progress, wait_st, abort;
  assign accept   = cmd_valid && cmd_ready;
  assign ar_hs    = m_arvalid && s_arready;
  assign r_hs     = m_rready && s_rvalid;
  assign aw_hs    = m_awvalid && s_awready;
  assign w_hs     = m_wvalid && s_wready;
  assign b_hs     = m_bready && s_bvalid;
  assign progress = ar_hs || r_hs || aw_hs || w_hs || b_hs;
  assign wait_st  = state inside {RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP};
  // a handshake landing on the expiry cycle wins: the responder already took the beat
  assign abort    = TIMEOUT != 0 && wait_st && wd == WD_W'(TIMEOUT) && !progress;
  assign m_araddr = addr;
  assign m_awaddr = addr;
  assign m_wdata  = wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         state_nx = accept ? (cmd_write ? WR_ADDR_DATA : RD_ADDR) : IDLE;
      RD_ADDR:      state_nx = ar_hs ? RD_DATA : abort ? DONE : RD_ADDR;
      RD_DATA:      state_nx = r_hs || abort ? DONE : RD_DATA;
      WR_ADDR_DATA: state_nx = (aw_done || aw_hs) && (w_done || w_hs) ? WR_RESP : abort ? DONE : WR_ADDR_DATA;
      WR_RESP:      state_nx = b_hs || abort ? DONE : WR_RESP;
      default:      state_nx = IDLE;
    endcase
  end
  // outputs decode the registered state, so reset clears every valid/ready asynchronously
  always_comb begin
    cmd_ready = state == IDLE;
    m_arvalid = state == RD_ADDR;
    m_rready  = state == RD_DATA;
    m_awvalid = state == WR_ADDR_DATA && !aw_done;
    m_wvalid  = state == WR_ADDR_DATA && !w_done;
    m_bready  = state == WR_RESP;
    rsp_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr      <= '0;
      wdata     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wd        <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
    end else begin
      if (accept) begin
        addr    <= cmd_addr;
        wdata   <= cmd_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      wd <= state_nx != state || progress ? '0 : wait_st ? wd + 1'b1 : wd;
      if (r_hs) begin
        rsp_rdata <= s_rdata;
        rsp_err   <= {1'b0, s_rresp != 2'b00};
      end
      if (b_hs) rsp_err <= {1'b0, s_bresp != 2'b00};
      if (abort) rsp_err <= 2'b10;
    end
endmodule

// File: tb/tb_axi_lite_initiator.sv
// tb_axi_lite_initiator: directed scenarios against a scripted responder
module tb_axi_lite_initiator;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic m_arvalid, s_arready = 1'b0, s_rvalid = 1'b0, m_rready;
  logic [3:0] m_araddr, m_awaddr;
  logic [7:0] s_rdata = '0, m_wdata;
  logic [1:0] s_rresp = '0, s_bresp = '0;
  logic m_awvalid, s_awready = 1'b0, m_wvalid, s_wready = 1'b0, s_bvalid = 1'b0, m_bready;
  int tests = 0, fails = 0;

  axi_lite_initiator #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .s_awready(s_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_responder();
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %0h exp 1", cmd_ready); end
    tests++; if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, rsp_valid} !== 6'b0) begin fails++; $display("FAIL reset_valids got %b exp 000000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, rsp_valid}); end
    tests++; if ({m_araddr, m_wdata, rsp_rdata, rsp_err} !== 22'h0) begin fails++; $display("FAIL reset_data got %h exp 0", {m_araddr, m_wdata, rsp_rdata, rsp_err}); end
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_read_zero_wait();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd3;
    s_arready = 1; s_rvalid = 1; s_rdata = 8'h5A; s_rresp = 2'b00;
    tick();
    cmd_valid = 0;
    tests++; if (m_arvalid !== 1'b1 || m_araddr !== 4'd3) begin fails++; $display("FAIL rd_ar got v=%0h a=%0h exp v=1 a=3", m_arvalid, m_araddr); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rd_cmd_ready got %0h exp 0", cmd_ready); end
    tick();
    tests++; if (m_rready !== 1'b1 || m_arvalid !== 1'b0) begin fails++; $display("FAIL rd_rready got r=%0h ar=%0h exp r=1 ar=0", m_rready, m_arvalid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_err !== 2'b00) begin fails++; $display("FAIL rd_rsp got v=%0h d=%0h e=%0h exp v=1 d=5a e=0", rsp_valid, rsp_rdata, rsp_err); end
    idle_responder();
    tick();
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rd_after got v=%0h rdy=%0h exp v=0 rdy=1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_write_split();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd7; cmd_wdata = 8'hC3;
    tick();
    cmd_valid = 0;
    tests++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 4'd7 || m_wdata !== 8'hC3) begin fails++; $display("FAIL wr_start got aw=%0h w=%0h a=%0h d=%0h exp 1 1 7 c3", m_awvalid, m_wvalid, m_awaddr, m_wdata); end
    s_awready = 1;
    tick();
    s_awready = 0;
    tests++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1 || m_bready !== 1'b0) begin fails++; $display("FAIL wr_aw_first got aw=%0h w=%0h b=%0h exp 0 1 0", m_awvalid, m_wvalid, m_bready); end
    tick();
    tests++; if (m_wvalid !== 1'b1 || m_wdata !== 8'hC3 || m_bready !== 1'b0) begin fails++; $display("FAIL wr_w_held got w=%0h d=%0h b=%0h exp 1 c3 0", m_wvalid, m_wdata, m_bready); end
    s_wready = 1;
    tick();
    s_wready = 0;
    tests++; if (m_wvalid !== 1'b0 || m_bready !== 1'b1) begin fails++; $display("FAIL wr_bready got w=%0h b=%0h exp 0 1", m_wvalid, m_bready); end
    s_bvalid = 1; s_bresp = 2'b00;
    tick();
    idle_responder();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b00 || rsp_rdata !== 8'h5A || m_bready !== 1'b0) begin fails++; $display("FAIL wr_rsp got v=%0h e=%0h d=%0h b=%0h exp 1 0 5a 0", rsp_valid, rsp_err, rsp_rdata, m_bready); end
    tick();
  endtask

  task automatic test_error_responses();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd1; cmd_wdata = 8'h0F;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b11;
    tick();
    cmd_valid = 0;
    tick();
    tests++; if (m_bready !== 1'b1) begin fails++; $display("FAIL wr_err_bready got %0h exp 1", m_bready); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b01 || rsp_rdata !== 8'h5A) begin fails++; $display("FAIL wr_err_rsp got v=%0h e=%0h d=%0h exp 1 1 5a", rsp_valid, rsp_err, rsp_rdata); end
    idle_responder();
    tick();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd9;
    s_arready = 1; s_rvalid = 1; s_rdata = 8'h96; s_rresp = 2'b10;
    tick();
    cmd_valid = 0;
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b01 || rsp_rdata !== 8'h96) begin fails++; $display("FAIL rd_err_rsp got v=%0h e=%0h d=%0h exp 1 1 96", rsp_valid, rsp_err, rsp_rdata); end
    idle_responder();
    tick();
  endtask

  task automatic test_timeout();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd1;
    tick();
    cmd_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      tests++; if (m_arvalid !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL to_wait%0d got ar=%0h v=%0h exp 1 0", i, m_arvalid, rsp_valid); end
      tick();
    end
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin fails++; $display("FAIL to_rsp got v=%0h e=%0h ar=%0h r=%0h exp 1 2 0 0", rsp_valid, rsp_err, m_arvalid, m_rready); end
    s_rvalid = 1; s_rdata = 8'hFF;
    tick();
    tests++; if (m_rready !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL to_late got r=%0h v=%0h rdy=%0h exp 0 0 1", m_rready, rsp_valid, cmd_ready); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h96 || rsp_err !== 2'b10) begin fails++; $display("FAIL to_ignored got v=%0h d=%0h e=%0h exp 0 96 2", rsp_valid, rsp_rdata, rsp_err); end
    idle_responder();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd5; cmd_wdata = 8'h44;
    s_awready = 1; s_wready = 1;
    tick();
    cmd_valid = 0;
    tick();
    tests++; if (m_bready !== 1'b1) begin fails++; $display("FAIL rst_pre_bready got %0h exp 1", m_bready); end
    #2 reset_n = 0;
    #1;
    tests++; if (m_bready !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_async got b=%0h rdy=%0h exp 0 1", m_bready, cmd_ready); end
    idle_responder();
    s_bvalid = 1;
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_bready !== 1'b0) begin fails++; $display("FAIL rst_after%0d got v=%0h rdy=%0h b=%0h exp 0 1 0", i, rsp_valid, cmd_ready, m_bready); end
    end
    idle_responder();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd2;
    s_arready = 1; s_rvalid = 1; s_rdata = 8'h11; s_rresp = 2'b00;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b00;
    tick();
    cmd_write = 1; cmd_addr = 4'd4; cmd_wdata = 8'h22;
    tests++; if (cmd_ready !== 1'b0 || m_awvalid !== 1'b0 || m_arvalid !== 1'b1) begin fails++; $display("FAIL b2b_busy got rdy=%0h aw=%0h ar=%0h exp 0 0 1", cmd_ready, m_awvalid, m_arvalid); end
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h11) begin fails++; $display("FAIL b2b_first got v=%0h d=%0h exp 1 11", rsp_valid, rsp_rdata); end
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0h exp 1", cmd_ready); end
    tick();
    cmd_valid = 0;
    tests++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 4'd4 || m_wdata !== 8'h22) begin fails++; $display("FAIL b2b_second got aw=%0h w=%0h a=%0h d=%0h exp 1 1 4 22", m_awvalid, m_wvalid, m_awaddr, m_wdata); end
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b00 || rsp_rdata !== 8'h11) begin fails++; $display("FAIL b2b_rsp got v=%0h e=%0h d=%0h exp 1 0 11", rsp_valid, rsp_err, rsp_rdata); end
    idle_responder();
    tick();
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_end got v=%0h rdy=%0h exp 0 1", rsp_valid, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_split();
    test_error_responses();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
